// File: rtl/dsp_frame_sequencer.sv
// dsp_frame_sequencer: instruction-memory PC generator for the DSP core.
// Each program pass is aligned to an external sample tick. Overrun (tick
// before the program finished) and loss of sample lock are detected, and
// parameter-bank swaps are applied only on frame boundaries.
// Interface semantics: sample_tick, swap_req and overrun_clr are single-cycle
// pulses sampled on the rising clock edge; run_en is a level. All outputs are
// registered. frame_start and swap_ack are one-cycle pulses.
module dsp_frame_sequencer #(
  parameter int CYCLES_PER_SAMPLE = 2048,
  parameter int PROGRAM_LEN       = 2048,
  parameter int PC_WIDTH          = (PROGRAM_LEN > 1) ? $clog2(PROGRAM_LEN) : 1,
  parameter int SLACK             = 16,
  parameter int BANK_BITS         = 1,
  parameter int FRAME_CNT_WIDTH   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_tick,
  input  logic                       run_en,
  input  logic                       swap_req,
  input  logic                       overrun_clr,
  output logic [PC_WIDTH-1:0]        pc,
  output logic                       exec_en,
  output logic                       frame_start,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic [BANK_BITS-1:0]       param_bank,
  output logic                       swap_ack,
  output logic                       locked,
  output logic                       overrun,
  // debug view of the sequencer state: 0 IDLE, 1 WAIT_SYNC, 2 RUN, 3 HOLD
  output logic [1:0]                 dbg_state
);

  // The watchdog must be able to hold the full window value.
  localparam int WD_LIMIT = CYCLES_PER_SAMPLE + SLACK;
  localparam int WD_WIDTH = $clog2(WD_LIMIT + 1);

  localparam logic [PC_WIDTH-1:0] PC_LAST = PC_WIDTH'(PROGRAM_LEN - 1);
  localparam logic [WD_WIDTH-1:0] WD_LAST = WD_WIDTH'(WD_LIMIT - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    RUN       = 2'd2,
    HOLD      = 2'd3
  } state_t;

  state_t              state_q;
  logic [WD_WIDTH-1:0] watchdog;
  logic                swap_pending;

  logic pc_last;
  logic wd_expired;
  logic accept_tick;
  logic overrun_hit;

  assign dbg_state = state_q;

  // Decode whether this cycle's tick starts a frame and whether it is an overrun.
  // In RUN a tick is accepted unless the frame is stopping on its last
  // instruction (run_en low), where leaving to IDLE takes priority.
  always_comb begin
    pc_last     = (pc == PC_LAST);
    wd_expired  = (watchdog == WD_LAST);
    accept_tick = 1'b0;
    case (state_q)
      WAIT_SYNC: accept_tick = run_en && sample_tick;
      RUN:       accept_tick = sample_tick && (run_en || !pc_last);
      HOLD:      accept_tick = run_en && sample_tick;
      default:   accept_tick = 1'b0;
    endcase
    overrun_hit = accept_tick && (state_q == RUN) && !pc_last;
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      pc           <= '0;
      exec_en      <= 1'b0;
      frame_start  <= 1'b0;
      frame_count  <= '0;
      param_bank   <= '0;
      swap_ack     <= 1'b0;
      locked       <= 1'b0;
      overrun      <= 1'b0;
      swap_pending <= 1'b0;
      watchdog     <= '0;
    end else begin
      frame_start <= 1'b0;
      swap_ack    <= 1'b0;

      // Clear first so a coincident overrun event wins.
      if (overrun_clr) overrun <= 1'b0;
      if (overrun_hit) overrun <= 1'b1;

      if (accept_tick) begin
        // Frame start: pc=0 of a new pass, swap applied on this same edge.
        state_q     <= RUN;
        pc          <= '0;
        exec_en     <= 1'b1;
        frame_start <= 1'b1;
        frame_count <= frame_count + FRAME_CNT_WIDTH'(1);
        watchdog    <= '0;
        locked      <= 1'b1;
        if (swap_pending || swap_req) begin
          param_bank <= param_bank + BANK_BITS'(1);
          swap_ack   <= 1'b1;
        end
        swap_pending <= 1'b0;
      end else begin
        if (swap_req) swap_pending <= 1'b1;
        case (state_q)
          IDLE: begin
            pc      <= '0;
            exec_en <= 1'b0;
            if (run_en) state_q <= WAIT_SYNC;
          end
          WAIT_SYNC: begin
            pc      <= '0;
            exec_en <= 1'b0;
            if (!run_en) begin
              state_q <= IDLE;
              locked  <= 1'b0;
            end
          end
          RUN: begin
            watchdog <= watchdog + WD_WIDTH'(1);
            if (pc_last) begin
              pc      <= '0;
              exec_en <= 1'b0;
              if (run_en) begin
                state_q <= HOLD;
              end else begin
                state_q <= IDLE;
                locked  <= 1'b0;
              end
            end else if (wd_expired) begin
              state_q <= WAIT_SYNC;
              locked  <= 1'b0;
              pc      <= '0;
              exec_en <= 1'b0;
            end else begin
              pc <= pc + PC_WIDTH'(1);
            end
          end
          HOLD: begin
            watchdog <= watchdog + WD_WIDTH'(1);
            pc       <= '0;
            exec_en  <= 1'b0;
            if (!run_en) begin
              state_q <= IDLE;
              locked  <= 1'b0;
            end else if (wd_expired) begin
              state_q <= WAIT_SYNC;
              locked  <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dsp_frame_sequencer.sv
// Bench for dsp_frame_sequencer: directed scenarios followed by randomized
// ticks, swaps, clears, run_en changes and resets, checked every cycle
// against a frame-age reference model through an expected-output queue.
module tb_dsp_frame_sequencer;

  localparam int C   = 16;
  localparam int PL  = 12;
  localparam int S   = 4;
  localparam int FCW = 4;
  localparam int BB  = 1;
  localparam int PCW = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_HOLD = 2'd3;

  typedef struct packed {
    logic [PCW-1:0] pc;
    logic           exec;
    logic           fs;
    logic [FCW-1:0] fc;
    logic [BB-1:0]  bank;
    logic           ack;
    logic           lock;
    logic           ovr;
    logic [1:0]     st;
  } out_t;

  localparam int OUT_W = $bits(out_t);

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sample_tick = 1'b0;
  logic run_en = 1'b0;
  logic swap_req = 1'b0;
  logic overrun_clr = 1'b0;
  logic [PCW-1:0] pc;
  logic exec_en;
  logic frame_start;
  logic [FCW-1:0] frame_count;
  logic [BB-1:0] param_bank;
  logic swap_ack;
  logic locked;
  logic overrun;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  dsp_frame_sequencer #(
    .CYCLES_PER_SAMPLE(C),
    .PROGRAM_LEN(PL),
    .PC_WIDTH(PCW),
    .SLACK(S),
    .BANK_BITS(BB),
    .FRAME_CNT_WIDTH(FCW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .sample_tick(sample_tick),
    .run_en(run_en),
    .swap_req(swap_req),
    .overrun_clr(overrun_clr),
    .pc(pc),
    .exec_en(exec_en),
    .frame_start(frame_start),
    .frame_count(frame_count),
    .param_bank(param_bank),
    .swap_ack(swap_ack),
    .locked(locked),
    .overrun(overrun),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  logic [OUT_W-1:0] exp_q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The model tracks "age" = cycles since the latest frame start while a
  // frame is active; pc, exec_en and RUN/HOLD are all derived from it.
  int m_mode;   // 0 idle, 1 waiting for a tick, 2 frame active
  int m_age;
  int m_fc;
  int m_bank;
  bit m_pend;
  bit m_lock;
  bit m_ovr;
  bit m_fs;
  bit m_ack;
  bit cur_run;

  task automatic model_step(input bit tk, input bit run, input bit sw, input bit clr, input bit rst);
    bit start;
    start = 1'b0;
    m_fs  = 1'b0;
    m_ack = 1'b0;
    if (rst) begin
      m_mode = 0; m_age = 0; m_fc = 0; m_bank = 0;
      m_pend = 1'b0; m_lock = 1'b0; m_ovr = 1'b0;
    end else begin
      if (clr) m_ovr = 1'b0;
      case (m_mode)
        0: if (run) m_mode = 1;
        1: begin
          if (!run) m_mode = 0;
          else if (tk) start = 1'b1;
        end
        default: begin
          if (!run && m_age >= PL - 1) begin
            m_mode = 0;
            m_lock = 1'b0;
          end else if (tk) begin
            if (m_age < PL - 1) m_ovr = 1'b1;
            start = 1'b1;
          end else if (m_age == C + S - 1) begin
            m_mode = 1;
            m_lock = 1'b0;
          end else begin
            m_age++;
          end
        end
      endcase
      if (start) begin
        m_mode = 2;
        m_age  = 0;
        m_fc   = (m_fc + 1) % (1 << FCW);
        m_lock = 1'b1;
        m_fs   = 1'b1;
        if (m_pend || sw) begin
          m_bank = (m_bank + 1) % (1 << BB);
          m_ack  = 1'b1;
        end
        m_pend = 1'b0;
      end else if (sw) begin
        m_pend = 1'b1;
      end
    end
  endtask

  function automatic logic [OUT_W-1:0] model_out();
    out_t o;
    bit act;
    act    = (m_mode == 2) && (m_age < PL);
    o.pc   = act ? PCW'(m_age) : '0;
    o.exec = act;
    o.fs   = m_fs;
    o.fc   = FCW'(m_fc);
    o.bank = BB'(m_bank);
    o.ack  = m_ack;
    o.lock = m_lock;
    o.ovr  = m_ovr;
    if (m_mode == 0)      o.st = ST_IDLE;
    else if (m_mode == 1) o.st = ST_WAIT;
    else if (act)         o.st = ST_RUN;
    else                  o.st = ST_HOLD;
    return o;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input bit tk, input bit sw, input bit clr, input bit rst);
    @(negedge clk);
    sample_tick = tk;
    swap_req    = sw;
    overrun_clr = clr;
    reset       = rst;
    run_en      = cur_run;
    model_step(tk, cur_run, sw, clr, rst);
    exp_q.push_back(model_out());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  // ---------------- monitor ----------------
  initial begin
    out_t e;
    out_t a;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e      = exp_q.pop_front();
        a.pc   = pc;
        a.exec = exec_en;
        a.fs   = frame_start;
        a.fc   = frame_count;
        a.bank = param_bank;
        a.ack  = swap_ack;
        a.lock = locked;
        a.ovr  = overrun;
        a.st   = dbg_state;
        chk("pc",          32'(a.pc),   32'(e.pc));
        chk("exec_en",     32'(a.exec), 32'(e.exec));
        chk("frame_start", 32'(a.fs),   32'(e.fs));
        chk("frame_count", 32'(a.fc),   32'(e.fc));
        chk("param_bank",  32'(a.bank), 32'(e.bank));
        chk("swap_ack",    32'(a.ack),  32'(e.ack));
        chk("locked",      32'(a.lock), 32'(e.lock));
        chk("overrun",     32'(a.ovr),  32'(e.ovr));
        chk("state",       32'(a.st),   32'(e.st));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    cur_run = 1'b0;
    // reset state
    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(2);
    // ticks in IDLE are ignored
    tick();
    idle(1);

    // nominal: three frames at the nominal tick period
    cur_run = 1'b1;
    idle(3);
    repeat (3) begin
      tick();
      idle(C - 1);
    end

    // overrun: ticks 8 apart, then clear, then a legal tick on the last instruction
    tick();
    idle(7);
    tick();
    idle(3);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    idle(7);
    tick();
    idle(C - 1);

    // overrun_clr coincident with an overrun event: set wins
    tick();
    idle(4);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    idle(C - 1);
    step(1'b0, 1'b0, 1'b1, 1'b0);

    // swap: two requests mid-frame collapse into one swap, then swap with tick
    tick();
    idle(3);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    idle(8);
    tick();
    idle(C - 1);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    idle(C - 1);

    // lock loss: no ticks for well over the window, then relock
    idle(30);
    tick();
    idle(C - 1);
    // tick exactly at the window edge is still accepted
    tick();
    idle(C + S - 1);
    tick();
    idle(C - 1);

    // run_en drop at pc=5: frame completes, then IDLE; ticks ignored
    tick();
    idle(5);
    cur_run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      idle(C - 1);
      tick();
    end
    // swap request in IDLE stays pending until the first frame start
    step(1'b0, 1'b1, 1'b0, 1'b0);
    cur_run = 1'b1;
    idle(2);
    tick();
    idle(C - 1);

    // frame_count wrap: 17 frames
    for (int i = 0; i < 17; i++) begin
      tick();
      idle(PL);
    end

    // reset mid-frame at pc=6
    tick();
    idle(6);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    idle(3);

    // randomized traffic
    for (int f = 0; f < 250; f++) begin
      int gap;
      gap = $urandom_range(6, 24);
      tick();
      for (int i = 0; i < gap; i++) begin
        bit sw;
        bit clr;
        bit rst;
        sw  = ($urandom_range(0, 15) == 0);
        clr = ($urandom_range(0, 15) == 0);
        rst = ($urandom_range(0, 599) == 0);
        if ($urandom_range(0, 149) == 0) cur_run = ~cur_run;
        if (!cur_run && $urandom_range(0, 7) == 0) cur_run = 1'b1;
        step(1'b0, sw, clr, rst);
      end
    end

    idle(2);
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dsp_frame_sequencer.md
Name: dsp_frame_sequencer

Overview:
- Parametrised successor to the free-running DSP program counter.
- Generates the instruction-memory PC for the DSP core. Aligns each program pass to an external sample tick instead of relying on counter overflow.
- Supports program lengths and clock ratios that are not powers of two. Detects overrun and loss of sample lock.
- Performs glitch-free parameter-bank swaps on frame boundaries. Sits between the instruction memory and the ADAT/SPI side of the DSP top.

Parameters:
- CYCLES_PER_SAMPLE, 2048, nominal clk cycles between sample ticks (any integer ≥ 4).
- PROGRAM_LEN, 2048, instructions executed per frame; 1 ≤ PROGRAM_LEN ≤ CYCLES_PER_SAMPLE.
- PC_WIDTH, $clog2(PROGRAM_LEN) (minimum 1), width of pc.
- SLACK, 16, extra cycles tolerated beyond CYCLES_PER_SAMPLE before lock is declared lost.
- BANK_BITS, 1, width of param_bank (number of banks = 2**BANK_BITS).
- FRAME_CNT_WIDTH, 16, width of frame_count.

Ports:
- clk  input  1  DSP clock.
- reset  input  1  synchronous, active-high reset.
- sample_tick  input  1  single-cycle pulse per audio sample, already synchronised to clk.
- run_en  input  1  level; enables sequencing.
- swap_req  input  1  single-cycle pulse; request advance to next parameter bank.
- overrun_clr  input  1  pulse; clears the sticky overrun flag.
- pc  output  PC_WIDTH  instruction address.
- exec_en  output  1  high while pc is a valid instruction of the current frame.
- frame_start  output  1  one-cycle pulse coincident with pc=0 of each frame.
- frame_count  output  FRAME_CNT_WIDTH  frames started since reset; wraps modulo 2**FRAME_CNT_WIDTH.
- param_bank  output  BANK_BITS  active parameter bank.
- swap_ack  output  1  one-cycle pulse when a pending swap is applied.
- locked  output  1  high while ticks arrive within the watchdog window.
- overrun  output  1  sticky: a tick arrived before the program finished.

Behaviour:
- Reset values: state IDLE; pc=0, exec_en=0, frame_start=0, frame_count=0, param_bank=0, swap_ack=0, locked=0, overrun=0; swap-pending=0, watchdog=0. Reset mid-frame aborts immediately, with the same values.
- All outputs are registered.
- IDLE: pc=0, exec_en=0. run_en=1 -> WAIT_SYNC.
- WAIT_SYNC: sample_tick -> RUN. run_en=0 -> IDLE.
- Frame start: a tick accepted in cycle T gives pc=0, exec_en=1 and frame_start=1 in cycle T+1. In the same edge, frame_count increments, watchdog clears and locked becomes 1.
- RUN: pc increments by 1 each cycle. When pc=PROGRAM_LEN-1, the next cycle enters HOLD with pc=0 and exec_en=0. There is no wrap by overflow.
- HOLD: pc=0, exec_en=0. sample_tick -> new frame start (RUN).
- Tick while in RUN with pc≠PROGRAM_LEN-1:
  - overrun<=1 (sticky) and the frame restarts as a normal frame start. Remaining instructions are dropped.
  - A tick on the last instruction cycle is a legal back-to-back frame, not an overrun.
- Watchdog: counts clk cycles in RUN/HOLD and clears at each frame start. On reaching CYCLES_PER_SAMPLE+SLACK with no tick: go to WAIT_SYNC, locked<=0, exec_en<=0, pc<=0.
- run_en=0 in RUN: the current frame completes, then IDLE (not HOLD). run_en=0 in HOLD -> IDLE next cycle. locked drops on entering IDLE.
- Swap:
  - swap_req sets pending.
  - At the next frame start, if pending: param_bank<=param_bank+1 (wraps modulo 2**BANK_BITS) in the same edge as pc<=0, swap_ack=1 for that cycle, pending cleared.
  - swap_req coincident with the accepted tick applies to that frame.
  - Multiple requests before a frame start collapse into one swap.
  - swap_req during IDLE/WAIT_SYNC stays pending until the first frame start.
- overrun_clr coincident with a new overrun event: set wins. overrun_clr is not cleared by a lock loss.
- sample_tick in IDLE is ignored.

Test Plan:
Common parameters: CYCLES_PER_SAMPLE=16, PROGRAM_LEN=12, SLACK=4.
- Nominal: reset, run_en=1, tick every 16 cycles -> pc 0..11 with exec_en=1, then pc=0 with exec_en=0 for 4 cycles. frame_start once per frame; frame_count 1,2,3; locked=1 from the first frame; overrun=0.
- Overrun: ticks 8 cycles apart -> second tick restarts pc at 0 after pc=7, overrun=1. After overrun_clr, overrun=0. Tick exactly 12 cycles after the previous tick -> overrun stays 0.
- Lock loss: stop ticks after frame 2 -> after 20 cycles without a tick, locked=0 and state WAIT_SYNC. The next tick restarts a frame and gives locked=1.
- Swap: swap_req pulsed twice mid-frame -> at the next frame_start param_bank 0->1 and swap_ack pulses once. swap_req in the same cycle as a tick -> bank 1->0 on that frame.
- run_en drop mid-frame at pc=5 -> pc continues to 11, then IDLE with pc=0. Further ticks are ignored; frame_count is unchanged.
- frame_count wrap: FRAME_CNT_WIDTH=4, 17 frames -> frame_count reads 1. Reset asserted at pc=6 -> all outputs at reset values the next cycle.
